pp_accum_reg: RTL and testbench
===============================

# pp_accum_reg

Multi-lane partial-product accumulating register for the matrix-multiplier datapath. Each beat carries LANES partial products with per-lane carry-ins. The block sums each lane over a vector of beats terminated by in_last, then presents the per-lane sums with a beat count and overflow flags on a valid/ready output. It sits between the partial-product generator array and the result writeback stage, and replaces single-beat enable-gated product registers.

## Interface
- DATA_WIDTH, 8: operand width; each partial product is 2*DATA_WIDTH bits.
- LANES, 4: number of independent accumulation lanes.
- GUARD_BITS, 4: extra accumulator bits; ACC_WIDTH = 2*DATA_WIDTH+GUARD_BITS.
- CNT_WIDTH, 8: width of the beat counter.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*2*DATA_WIDTH  partial products; lane i at bits [i*2*DATA_WIDTH +: 2*DATA_WIDTH].
- in_cin  in  LANES  per-lane carry-in added to that lane's product.
- in_last  in  1  beat is the final beat of the vector.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*ACC_WIDTH  per-lane sums, packed by lane in the same way.
- out_count  out  CNT_WIDTH  beats in the vector.
- out_ovf  out  LANES  per-lane overflow flag for the vector.

## Operation
- Accept a beat when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Per lane on an accepted beat: sum = acc[i] + in_data lane i + in_cin[i], all zero-extended to ACC_WIDTH+1 bits. Bit ACC_WIDTH set means overflow.
- Non-last beat:
  - acc[i] <= sum, or the macro-defined overflow value on overflow.
  - ovf_acc[i] |= overflow.
  - cnt <= cnt+1, saturating at all-ones.
- Last beat:
  - out_data lane i <= final sum.
  - out_ovf <= ovf_acc | overflow.
  - out_count <= cnt+1, saturating.
  - out_valid <= 1.
  - acc, ovf_acc and cnt all clear to 0.
- A single-beat vector (in_last on the first beat) is legal: out_count = 1.
- Output handshake: out_data, out_count and out_ovf stay stable while out_valid && !out_ready. out_valid clears after out_valid && out_ready, unless a last beat is accepted in the same cycle.
- Simultaneous output handshake and accepted last beat: the output register reloads and out_valid stays 1. No bubble.
- Output stall (out_valid && !out_ready): in_ready = 0 and the accumulator holds.
- Implicit states:
  - EMPTY (cnt==0, !out_valid)
  - ACCUM (cnt>0)
  - FULL (out_valid)
  - ACCUM and FULL may coexist; FULL with !out_ready blocks input.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - acc=0, ovf_acc=0, cnt=0.
  - in_ready=1 in the cycle after reset deasserts.
- Reset mid-vector or mid-stall discards the partial sum and any pending result.
- Latency: out_valid rises 1 cycle after the last beat is accepted.
- Throughput: 1 beat per cycle while out_ready is held high.
- No combinational path from in_* to out_*.

## Configuration
- PP_ACC_SAT_EN defined: on overflow a lane clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the vector.
- PP_ACC_SAT_EN undefined: lanes wrap modulo 2^ACC_WIDTH.
- out_ovf is reported identically in both builds.

## Structure
- Package pp_pkg holds:
  - function acc_width(DATA_WIDTH, GUARD_BITS);
  - lane product and accumulator typedefs derived from it;
  - constant for the all-ones saturation value.
- Sub-module pp_lane_acc, one instance per lane via generate. It owns the adder, overflow detect, saturation/wrap mux and sticky flag.
- The top level owns the handshake, the beat counter and the output register.

## Test plan
Benches use DATA_WIDTH=8, LANES=2, GUARD_BITS=2 (ACC_WIDTH=18).
- Vector of 3 beats: lane0 = 5,7,9 with cin 0,1,0; lane1 = 0x100 each with cin 0 -> out_data lane0 = 22, lane1 = 0x300, out_count = 3, out_ovf = 0, one cycle after the last beat.
- Lane0 = 0xFFFF with cin=1 for 4 beats:
  - PP_ACC_SAT_EN defined -> lane0 = 0x3FFFF, out_ovf[0] = 1.
  - Undefined -> lane0 = 0, out_ovf[0] = 1.
  - Lane1 stays at its correct sum with out_ovf[1] = 0.
- Hold out_ready=0 with a result pending -> in_ready=0 and result fields stable for 5 cycles. Raise out_ready -> handshake completes and in_ready=1 in the same cycle.
- Back-to-back single-beat vectors 1, 2, 3 with out_ready=1 -> out_valid held high for 3 consecutive cycles with out_data lane0 = 1, 2, 3 and out_count = 1 each.
- Assert reset after 2 beats (lane0 = 10, 20). Then send one last beat of 4 -> lane0 = 4, out_count = 1.

Source files
------------

// File: rtl/pp_accum_reg_pkg.sv
// Shared sizing helpers and types for the partial-product accumulator (pp_accum_reg).
// The PP_ACC_SAT_EN build option is consumed in pp_lane_acc.
package pp_pkg;

  function automatic int acc_width(input int data_width, input int guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_GUARD_BITS = 4;
  localparam int DEF_ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_GUARD_BITS);

  typedef logic [2*DEF_DATA_WIDTH-1:0] pp_prod_t;
  typedef logic [DEF_ACC_WIDTH-1:0]    pp_acc_t;

  // Clamp value used when saturation is enabled in the default configuration.
  localparam pp_acc_t ACC_SAT_VAL = {DEF_ACC_WIDTH{1'b1}};

endpackage

// File: rtl/pp_accum_reg_lane_acc.sv
// One accumulation lane: adder, overflow detect, saturate/wrap select and sticky flag.
// Define PP_ACC_SAT_EN to clamp on overflow; otherwise the lane wraps.
module pp_lane_acc
  import pp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GUARD_BITS = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          beat_en_i,
  input  logic                                          beat_last_i,
  input  logic [2*DATA_WIDTH-1:0]                       pp_i,
  input  logic                                          cin_i,
  output logic [acc_width(DATA_WIDTH, GUARD_BITS)-1:0]  res_o,
  output logic                                          ovf_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, GUARD_BITS);
  localparam int PP_W  = 2 * DATA_WIDTH;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W:0]   sum_s;
  logic             lane_ovf_s;
  logic [ACC_W-1:0] next_s;

  // Beat sum, overflow detect and the value the lane would hold after this beat.
  always_comb begin
    sum_s      = {1'b0, acc_q} + {{(ACC_W+1-PP_W){1'b0}}, pp_i} + {{ACC_W{1'b0}}, cin_i};
    lane_ovf_s = sum_s[ACC_W];
`ifdef PP_ACC_SAT_EN
    // Once clamped, the lane keeps reporting the clamp value until the vector ends.
    if (lane_ovf_s || ovf_acc_q) begin
      next_s = {ACC_W{1'b1}};
    end else begin
      next_s = sum_s[ACC_W-1:0];
    end
`else
    next_s = sum_s[ACC_W-1:0];
`endif
    res_o = next_s;
    ovf_o = ovf_acc_q | lane_ovf_s;
  end

  // Next-state for the running sum and sticky overflow flag.
  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    if (beat_en_i) begin
      if (beat_last_i) begin
        acc_d     = {ACC_W{1'b0}};
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = next_s;
        ovf_acc_d = ovf_o;
      end
    end else begin
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= {ACC_W{1'b0}};
      ovf_acc_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

endmodule

// File: rtl/pp_accum_reg.sv
// Multi-lane partial-product accumulating register with valid/ready in and out.
// Build option PP_ACC_SAT_EN selects saturating lanes (see pp_lane_acc).
module pp_accum_reg
  import pp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int GUARD_BITS = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [LANES*2*DATA_WIDTH-1:0]                      in_data,
  input  logic [LANES-1:0]                                   in_cin,
  input  logic                                               in_last,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [LANES*acc_width(DATA_WIDTH, GUARD_BITS)-1:0] out_data,
  output logic [CNT_WIDTH-1:0]                               out_count,
  output logic [LANES-1:0]                                   out_ovf
);

  localparam int ACC_W = acc_width(DATA_WIDTH, GUARD_BITS);
  localparam int PP_W  = 2 * DATA_WIDTH;

  logic                   accept_s;
  logic [LANES*ACC_W-1:0] lane_res_s;
  logic [LANES-1:0]       lane_ovf_s;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc_s;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic [LANES-1:0]       out_ovf_q, out_ovf_d;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pp_lane_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .GUARD_BITS (GUARD_BITS)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .beat_en_i   (accept_s),
      .beat_last_i (in_last),
      .pp_i        (in_data[g*PP_W +: PP_W]),
      .cin_i       (in_cin[g]),
      .res_o       (lane_res_s[g*ACC_W +: ACC_W]),
      .ovf_o       (lane_ovf_s[g])
    );
  end

  // Beat counter saturates rather than wrapping so long vectors report all-ones.
  assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Beat counter and output register next-state; a last beat reloads even during a handshake.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (accept_s && in_last) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_res_s;
      out_count_d = cnt_inc_s;
      out_ovf_d   = lane_ovf_s;
      cnt_d       = {CNT_WIDTH{1'b0}};
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        cnt_d = cnt_inc_s;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= {CNT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {(LANES*ACC_W){1'b0}};
      out_count_q <= {CNT_WIDTH{1'b0}};
      out_ovf_q   <= {LANES{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_pp_accum_reg.sv
// Directed plus randomized bench for pp_accum_reg; expected results come from a
// whole-vector arithmetic model (true integer totals, then wrap or clamp).
module tb_pp_accum_reg;
  localparam int DW = 8;
  localparam int LN = 2;
  localparam int GB = 2;
  localparam int CW = 8;
  localparam int AW = 2*DW + GB;
  localparam int PW = 2*DW;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [LN*PW-1:0] in_data;
  logic [LN-1:0]    in_cin;
  logic [LN*AW-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic [LN-1:0]    out_ovf;

  pp_accum_reg #(.DATA_WIDTH(DW), .LANES(LN), .GUARD_BITS(GB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*AW-1:0] data;
    logic [CW-1:0]    cnt;
    logic [LN-1:0]    ovf;
  } res_t;

  int     checks = 0;
  int     failures = 0;
  res_t   expq[$];
  longint tot[LN];
  int     nbeats;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < LN; i++) tot[i] = 0;
    nbeats = 0;
  endtask

  function automatic res_t model_close();
    res_t   r;
    longint lim;
    longint v;
    lim = longint'(1) << AW;
    r.data = '0;
    r.ovf  = '0;
    for (int i = 0; i < LN; i++) begin
      r.ovf[i] = (tot[i] >= lim);
`ifdef PP_ACC_SAT_EN
      v = r.ovf[i] ? lim - 1 : tot[i];
`else
      v = tot[i] % lim;
`endif
      r.data[i*AW +: AW] = v[AW-1:0];
    end
    r.cnt = (nbeats > 255) ? 8'hFF : nbeats[CW-1:0];
    return r;
  endfunction

  // Called at a falling edge while out_ready is high.
  task automatic check_out_cycle();
    res_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_data", {28'd0, out_data}, {28'd0, e.data});
      chk("out_count", {56'd0, out_count}, {56'd0, e.cnt});
      chk("out_ovf", {62'd0, out_ovf}, {62'd0, e.ovf});
    end else begin
      chk("out_idle", {63'd0, out_valid}, 64'd0);
    end
  endtask

  task automatic send(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                      input logic [LN-1:0] cin, input logic last);
    in_valid = 1'b1;
    in_data  = {p1, p0};
    in_cin   = cin;
    in_last  = last;
    @(negedge clk);
    check_out_cycle();
    chk("in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    tot[0] += longint'(p0) + longint'(cin[0]);
    tot[1] += longint'(p1) + longint'(cin[1]);
    nbeats++;
    if (last) begin
      expq.push_back(model_close());
      reset_model();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    check_out_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    int   len;
    logic [PW-1:0] r0, r1;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_cin = '0; out_ready = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {28'd0, out_data}, 64'd0);
    chk("rst_out_count", {56'd0, out_count}, 64'd0);
    chk("rst_out_ovf", {62'd0, out_ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Three-beat vector
    send(16'd5, 16'h0100, 2'b00, 1'b0);
    send(16'd7, 16'h0100, 2'b01, 1'b0);
    send(16'd9, 16'h0100, 2'b00, 1'b1);
    @(negedge clk);
    chk("t1_lane0", {46'd0, out_data[AW-1:0]}, 64'd22);
    chk("t1_lane1", {46'd0, out_data[2*AW-1:AW]}, 64'h300);
    chk("t1_count", {56'd0, out_count}, 64'd3);
    check_out_cycle();
    @(posedge clk); #1;
    idle();

    // Lane 0 overflow, lane 1 clean
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'h1234, 2'b01, (i == 3));
    @(negedge clk);
`ifdef PP_ACC_SAT_EN
    chk("t2_lane0_sat", {46'd0, out_data[AW-1:0]}, 64'h3FFFF);
`else
    chk("t2_lane0_wrap", {46'd0, out_data[AW-1:0]}, 64'd0);
`endif
    chk("t2_lane1", {46'd0, out_data[2*AW-1:AW]}, 64'h48D0);
    chk("t2_ovf", {62'd0, out_ovf}, 64'd1);
    check_out_cycle();
    @(posedge clk); #1;

    // Output stall for 5 cycles with a competing beat offered
    send(16'd3, 16'd4, 2'b10, 1'b1);
    out_ready = 1'b0;
    e = expq[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = {16'hAAAA, 16'h5555}; in_cin = 2'b11; in_last = 1'b1;
      @(negedge clk);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_data", {28'd0, out_data}, {28'd0, e.data});
      chk("stall_count", {56'd0, out_count}, {56'd0, e.cnt});
      chk("stall_ovf", {62'd0, out_ovf}, {62'd0, e.ovf});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", {63'd0, in_ready}, 64'd1);
    check_out_cycle();
    @(posedge clk); #1;
    idle();
    send(16'd1, 16'd1, 2'b00, 1'b1);
    idle();

    // Back-to-back single-beat vectors
    send(16'd1, 16'd0, 2'b00, 1'b1);
    send(16'd2, 16'd0, 2'b00, 1'b1);
    send(16'd3, 16'd0, 2'b00, 1'b1);
    idle();
    idle();

    // Reset mid-vector discards the partial sum
    send(16'd10, 16'd0, 2'b00, 1'b0);
    send(16'd20, 16'd0, 2'b00, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    reset_model();
    idle();
    send(16'd4, 16'd0, 2'b00, 1'b1);
    @(negedge clk);
    chk("rst_vec_lane0", {46'd0, out_data[AW-1:0]}, 64'd4);
    chk("rst_vec_count", {56'd0, out_count}, 64'd1);
    check_out_cycle();
    @(posedge clk); #1;

    // Beat counter saturation
    for (int i = 0; i < 300; i++) send(16'd1, 16'd2, 2'b00, (i == 299));
    idle();

    // Random vectors
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        r0 = ($urandom_range(0, 2) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255))) : 16'($urandom);
        r1 = 16'($urandom);
        send(r0, r1, 2'($urandom), (b == len - 1));
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    idle();
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
